// File: rtl/mem_pipelined_be_if.sv
// Request/response bundle for mem_pipelined_be.
// slave: memory side; master: requester side.
interface mem_pipelined_be_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  EN;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] add;
  logic [DATA_WIDTH-1:0] Data_in;
  logic [NB-1:0]         byte_en;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  busy;
  logic                  err;

  modport slave (
    input  EN, wr_en, rd_en, add, Data_in, byte_en,
    output valid_out, Data_out, busy, err
  );

  modport master (
    output EN, wr_en, rd_en, add, Data_in, byte_en,
    input  valid_out, Data_out, busy, err
  );
endinterface

// File: rtl/mem_pipelined_be.sv
// Byte-enable RAM with pipelined reads and optional zero sweep.
// Ports: clk, rst (async low), bus (requests in; valid_out/Data_out/busy/err out).
module mem_pipelined_be #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst,
  mem_pipelined_be_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  word_t                 mem_q [DEPTH];
  logic [RD_LATENCY-1:0] vld_q;
  word_t                 dat_q [RD_LATENCY];
  logic                  err_q;

  logic  idle, req, wr_acc, rd_acc;
  word_t old_w, merged_w, rd_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= req & ~idle;
    end
  end

  assign idle   = (state_q == ST_IDLE);
  assign req    = bus.EN & (bus.wr_en | bus.rd_en);
  assign wr_acc = idle & bus.EN & bus.wr_en;
  assign rd_acc = idle & bus.EN & bus.rd_en;
  assign old_w  = mem_q[bus.add];

  always_comb begin
    merged_w = old_w;
    for (int i = 0; i < NB; i++) begin
      if (bus.byte_en[i]) merged_w[8*i +: 8] = bus.Data_in[8*i +: 8];
    end
  end

  // Write-first forwards the merged word; otherwise the pre-write word.
  assign rd_w = ((RDW_MODE != 0) && wr_acc) ? merged_w : old_w;

  // Array is never reset; the sweep clears it one word per edge.
  always_ff @(posedge clk) begin
    if (!idle) mem_q[cnt_q] <= '0;
    else if (wr_acc) mem_q[bus.add] <= merged_w;
  end

  // Data stages only load behind a valid so the last one holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int j = 0; j < RD_LATENCY; j++) dat_q[j] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= rd_w;
      for (int j = 1; j < RD_LATENCY; j++) begin
        vld_q[j] <= vld_q[j-1];
        if (vld_q[j-1]) dat_q[j] <= dat_q[j-1];
      end
    end
  end

  assign bus.valid_out = vld_q[RD_LATENCY-1];
  assign bus.Data_out  = dat_q[RD_LATENCY-1];
  assign bus.busy      = ~idle;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_pipelined_be.sv
// Scoreboard bench: two DUTs (L=1 read-old, L=3 write-first)
// share stimulus; a monitor checks each read stream in order.
module tb_mem_pipelined_be;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam int L0    = 1;
  localparam int L1    = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_pipelined_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  mem_pipelined_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  mem_pipelined_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L0),
    .RDW_MODE(0), .INIT_ON_RESET(1)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0));

  mem_pipelined_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L1),
    .RDW_MODE(1), .INIT_ON_RESET(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic          vo [2];
  logic [DW-1:0] dq [2];
  logic          er [2];
  logic          bz [2];
  assign vo[0] = if0.valid_out;
  assign vo[1] = if1.valid_out;
  assign dq[0] = if0.Data_out;
  assign dq[1] = if1.Data_out;
  assign er[0] = if0.err;
  assign er[1] = if1.err;
  assign bz[0] = if0.busy;
  assign bz[1] = if1.busy;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last [2];
  int            init_left = 0;
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  exp_t          mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] n,
                                          logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int qfront_cyc(int d);
    return (d == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (vo[d]) begin
          if (qsize(d) == 0) begin
            chk($sformatf("unexpected_valid%0d", d), vo[d], 1'b0);
          end else begin
            mon_e = qpop(d);
            chk($sformatf("rd_data%0d", d), dq[d], mon_e.data);
            chk($sformatf("rd_cycle%0d", d), cyc, mon_e.cyc);
            last[d] = mon_e.data;
          end
        end else begin
          chk($sformatf("hold%0d", d), dq[d], last[d]);
          if (qsize(d) > 0 && qfront_cyc(d) < cyc) begin
            chk($sformatf("missing_valid%0d", d), cyc, qfront_cyc(d));
            mon_e = qpop(d);
          end
        end
      end
    end
  end

  task automatic drive(bit en, bit we, bit re, logic [AW-1:0] a,
                       logic [DW-1:0] dat, logic [NB-1:0] be);
    if0.EN = en;  if0.wr_en = we;  if0.rd_en = re;
    if0.add = a;  if0.Data_in = dat; if0.byte_en = be;
    if1.EN = en;  if1.wr_en = we;  if1.rd_en = re;
    if1.add = a;  if1.Data_in = dat; if1.byte_en = be;
  endtask

  // Called at a falling edge; one request is sampled at the next rising edge.
  task automatic step(bit en, bit we, bit re, logic [AW-1:0] a,
                      logic [DW-1:0] dat, logic [NB-1:0] be);
    bit            bsy;
    bit            e_err;
    logic [DW-1:0] old;
    logic [DW-1:0] nw;
    bsy = (init_left > 0);
    chk("busy0", bz[0], bsy);
    chk("busy1", bz[1], bsy);
    drive(en, we, re, a, dat, be);
    e_err = en && (we || re) && bsy;
    if (en && !bsy) begin
      old = mdl[a];
      nw  = merge(old, dat, be);
      if (re) begin
        q0.push_back('{data: old, cyc: cyc + L0});
        q1.push_back('{data: (we ? nw : old), cyc: cyc + L1});
      end
      if (we) mdl[a] = nw;
    end
    @(posedge clk);
    if (init_left > 0) init_left--;
    @(negedge clk);
    chk("err0", er[0], e_err);
    chk("err1", er[1], e_err);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Called at a falling edge; releases rst at a later falling edge.
  task automatic do_reset(int hold);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    last[0] = '0;
    last[1] = '0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_valid%0d", d), vo[d], 1'b0);
        chk($sformatf("rst_data%0d", d), dq[d], '0);
        chk($sformatf("rst_err%0d", d), er[d], 1'b0);
        chk($sformatf("rst_busy%0d", d), bz[d], 1'b1);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    do_reset(3);

    // Sweep window: a write and a read are rejected with err.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) step(1'b1, 1'b1, 1'b0, 4'd9, 32'hCAFEF00D, 4'hF);
      else if (i == 6) step(1'b1, 1'b0, 1'b1, 4'd2, '0, '0);
      else idle_step();
    end
    idle_step();

    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 1'b1, 4'(a), '0, '0);

    step(1'b1, 1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 4'hF);
    step(1'b1, 1'b1, 1'b0, 4'd5, 32'h11223344, 4'b0101);
    step(1'b1, 1'b0, 1'b1, 4'd5, '0, '0);

    step(1'b1, 1'b1, 1'b0, 4'd1, 32'hA, 4'hF);
    step(1'b1, 1'b1, 1'b0, 4'd2, 32'hB, 4'hF);
    step(1'b1, 1'b1, 1'b0, 4'd3, 32'hC, 4'hF);
    step(1'b1, 1'b0, 1'b1, 4'd1, '0, '0);
    step(1'b1, 1'b0, 1'b1, 4'd2, '0, '0);
    step(1'b1, 1'b0, 1'b1, 4'd3, '0, '0);
    repeat (4) idle_step();

    step(1'b1, 1'b1, 1'b1, 4'd7, 32'hFFFFFFFF, 4'b0011);
    step(1'b1, 1'b0, 1'b1, 4'd7, '0, '0);

    step(1'b0, 1'b1, 1'b1, 4'd4, 32'h55AA55AA, 4'hF);
    step(1'b1, 1'b0, 1'b1, 4'd4, '0, '0);
    repeat (4) idle_step();

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
           4'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom));
    end
    repeat (4) idle_step();

    // Reads in flight when rst hits must never surface.
    step(1'b1, 1'b0, 1'b1, 4'd1, '0, '0);
    step(1'b1, 1'b0, 1'b1, 4'd2, '0, '0);
    do_reset(2);
    for (int i = 0; i < 8; i++) idle_step();
    do_reset(2);
    for (int i = 0; i < DEPTH; i++) idle_step();
    idle_step();
    for (int a = 0; a < DEPTH; a += 5) step(1'b1, 1'b0, 1'b1, 4'(a), '0, '0);
    repeat (6) idle_step();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_pipelined_be.md
Name: mem_pipelined_be

Overview:
Parametrised successor to the 16x16 single-port memory DUT.
- Configurable address and data width, byte-enable writes, and a configurable read pipeline latency.
- Selectable read-during-write semantics.
- Optional zero-initialisation sweep after reset, with a busy/err status pair.
- Sits behind the same clocking-block driven interface: same control and data naming, plus byte_en, busy and err.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
RD_LATENCY, 1, edges from read acceptance to valid_out; legal 1..4
RDW_MODE, 0, same-cycle read+write behaviour: 0 = read-old, 1 = write-first
INIT_ON_RESET, 1, 1 = zero every word after reset before accepting requests

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous assert, active-low
EN  in  1  request qualifier; when 0, wr_en/rd_en are ignored
wr_en  in  1  write request
rd_en  in  1  read request
add  in  ADDR_WIDTH  word address, shared by read and write
Data_in  in  DATA_WIDTH  write data
byte_en  in  NB  per-byte write enable; bit i covers Data_in[8i+7:8i]
valid_out  out  1  one-cycle pulse: Data_out holds read result
Data_out  out  DATA_WIDTH  read data; holds last value when valid_out=0
busy  out  1  init sweep in progress; requests rejected
err  out  1  one-cycle pulse: request rejected while busy

Behaviour:
Reset (rst=0, asynchronous):
- valid_out=0, Data_out=0, err=0, read pipeline emptied.
- busy=INIT_ON_RESET; init counter=0.
- Array contents are not reset by rst itself.

FSM, states INIT and IDLE:
- Reset enters INIT if INIT_ON_RESET=1, else IDLE.
- INIT: one word per edge, addresses 0..DEPTH-1, all bytes written 0.
- busy=1 throughout INIT, i.e. exactly DEPTH cycles after rst release.
- After the write of DEPTH-1, move to IDLE; busy=0 from the following cycle.
- rst asserted mid-INIT restarts the sweep from address 0.

Request acceptance, sampled at the rising edge:
- Accepted only if EN=1 and the FSM is in IDLE.
- EN=1 with (wr_en or rd_en) while busy: request dropped, err=1 for one cycle, no array or pipeline effect.
- EN=0: no action and no err, regardless of wr_en/rd_en.

Write:
- For each i with byte_en[i]=1, mem[add] byte i <= Data_in byte i.
- Other bytes are unchanged.
- byte_en=0 is a legal no-op.

Read:
- An accepted read at edge k produces valid_out=1 and Data_out=result during the cycle after edge k+RD_LATENCY-1.
- RD_LATENCY=1: visible right after edge k.
- Fully pipelined: one read per cycle, results returned in order, no gaps introduced.
- The array value is captured at edge k; later writes do not alter an in-flight result.

Simultaneous wr_en and rd_en (same add):
- RDW_MODE=0: the read returns the pre-write word.
- RDW_MODE=1: the read returns the merged word, i.e. new bytes where byte_en=1, old bytes elsewhere.
- The write happens in both modes.

Data_out:
- Updates only when valid_out=1; otherwise holds.

Address:
- Always in range by construction (DEPTH = 2**ADDR_WIDTH); no wrap logic needed.

Test Plan:
- INIT_ON_RESET=1, DEPTH=16: release rst -> busy=1 for exactly 16 cycles; then reads of addr 0..15 all return 0x00000000. A write at busy cycle 3 -> err pulse; addr unchanged.
- Write 0xDEADBEEF to addr 5 with byte_en=4'b1111, then byte_en=4'b0101 with Data_in=0x11223344 -> read addr 5 returns 0xDE22BE44.
- RD_LATENCY=3: back-to-back reads of addr 1,2,3 (preloaded 0xA,0xB,0xC) on consecutive edges -> valid_out high for 3 consecutive cycles starting 3 edges after the first read, data 0xA,0xB,0xC.
- Addr 7 holds 0x0; same-edge write 0xFFFFFFFF with rd_en, byte_en=4'b0011 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000FFFF. A subsequent read returns 0x0000FFFF in both modes.
- EN=0 with wr_en=rd_en=1 -> no valid_out, no err, memory unchanged.
- Assert rst at INIT cycle 8 for 2 cycles -> busy restarts; 16 further busy cycles after release; in-flight read pipeline cleared (no valid_out).
